// File: rtl/ebus_xfer.sv
// rtl/ebus_xfer.sv - EBOX-side EBUS transfer sequencer
//
// Runs one EBUS I/O cycle (DATAO/CONO/DATAI/CONI style) between the data path
// and a device: chip select and setup, processor demand, wait for the device
// transfer acknowledge, then wait for the acknowledge to drop. Both wait phases
// are bounded by TIMEOUT_CYCLES. Read data is captured for the ARL EBUS select.
//
// Parameters
//   SETUP_CYCLES    cycles CS/func/dev/data are stable before demand (>=1)
//   TIMEOUT_CYCLES  max cycles in DEMAND, and separately in RELEASE (>=2)
//
// Ports
//   clk          in   EBOX data-path clock
//   reset_n      in   asynchronous active-low reset
//   start        in   request a transfer (sampled only when idle)
//   isRead       in   1 = device->EBOX, 0 = EBOX->device (captured at start)
//   func[0:2]    in   EBUS function code (captured at start)
//   dev[0:6]     in   device select (captured at start)
//   wdata[0:35]  in   write word (captured at start)
//   ebusXfer     in   device transfer acknowledge
//   ebusDataIn   in   EBUS data from device
//   ebusCS       out  chip select
//   ebusFunc     out  registered function code
//   ebusDev      out  registered device select, zero-extended to 8 bits
//   ebusDemand   out  processor demand
//   ebusDriving  out  this block drives ebusDataOut onto the EBUS
//   ebusDataOut  out  registered write word, zero when not driving
//   rdata        out  captured read word, held until the next successful read
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse (success or timeout)
//   timeout      out  one-cycle pulse coincident with done on failure

module ebus_xfer #(
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        isRead,
   input  logic [0:2]  func,
   input  logic [0:6]  dev,
   input  logic [0:35] wdata,
   input  logic        ebusXfer,
   input  logic [0:35] ebusDataIn,
   output logic        ebusCS,
   output logic [0:2]  ebusFunc,
   output logic [0:7]  ebusDev,
   output logic        ebusDemand,
   output logic        ebusDriving,
   output logic [0:35] ebusDataOut,
   output logic [0:35] rdata,
   output logic        busy,
   output logic        done,
   output logic        timeout
);

   // One counter serves both the setup delay and the two timeout windows,
   // so it is sized for whichever bound is larger.
   localparam int CMAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_DEMAND,
      S_RELEASE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;

   logic          hold_rd, hold_rd_n;
   logic [0:2]    hold_func, hold_func_n;
   logic [0:6]    hold_dev, hold_dev_n;
   logic [0:35]   hold_wdata, hold_wdata_n;

   logic          active_n;
   logic          cs_n, demand_n, driving_n, done_n, timeout_n;
   logic [0:2]    func_n;
   logic [0:7]    dev_n;
   logic [0:35]   dataout_n, rdata_n;

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      hold_rd_n    = hold_rd;
      hold_func_n  = hold_func;
      hold_dev_n   = hold_dev;
      hold_wdata_n = hold_wdata;
      rdata_n      = rdata;
      done_n       = 1'b0;
      timeout_n    = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n      = S_SETUP;
               cnt_n        = '0;
               hold_rd_n    = isRead;
               hold_func_n  = func;
               hold_dev_n   = dev;
               hold_wdata_n = wdata;
            end
         end

         S_SETUP: begin
            if (cnt == CW'(SETUP_CYCLES - 1)) begin
               state_n = S_DEMAND;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         S_DEMAND: begin
            // An acknowledge on the last allowed cycle still counts as a
            // transfer: it is tested before the timeout bound.
            if (ebusXfer) begin
               state_n = S_RELEASE;
               cnt_n   = '0;
               if (hold_rd) begin
                  rdata_n = ebusDataIn;
               end
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state_n   = S_IDLE;
               done_n    = 1'b1;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         S_RELEASE: begin
            if (!ebusXfer) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state_n   = S_IDLE;
               done_n    = 1'b1;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Outputs are derived from the next state so that they are registered
      // yet change on the same edge as the state itself.
      active_n  = (state_n != S_IDLE);
      cs_n      = active_n;
      demand_n  = (state_n == S_DEMAND);
      driving_n = active_n && !hold_rd_n;
      dataout_n = driving_n ? hold_wdata_n : '0;
      func_n    = active_n ? hold_func_n : '0;
      dev_n     = active_n ? {1'b0, hold_dev_n} : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         hold_rd     <= 1'b0;
         hold_func   <= '0;
         hold_dev    <= '0;
         hold_wdata  <= '0;
         ebusCS      <= 1'b0;
         ebusFunc    <= '0;
         ebusDev     <= '0;
         ebusDemand  <= 1'b0;
         ebusDriving <= 1'b0;
         ebusDataOut <= '0;
         rdata       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         hold_rd     <= hold_rd_n;
         hold_func   <= hold_func_n;
         hold_dev    <= hold_dev_n;
         hold_wdata  <= hold_wdata_n;
         ebusCS      <= cs_n;
         ebusFunc    <= func_n;
         ebusDev     <= dev_n;
         ebusDemand  <= demand_n;
         ebusDriving <= driving_n;
         ebusDataOut <= dataout_n;
         rdata       <= rdata_n;
         busy        <= active_n;
         done        <= done_n;
         timeout     <= timeout_n;
      end
   end

endmodule

// File: tb/tb_ebus_xfer.sv
// tb/tb_ebus_xfer.sv - self-checking bench for ebus_xfer

module tb_ebus_xfer;

   localparam int S = 2;
   localparam int T = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        isRead = 1'b0;
   logic [2:0]  func = '0;
   logic [6:0]  dev = '0;
   logic [35:0] wdata = '0;
   logic        ebusXfer = 1'b0;
   logic [35:0] ebusDataIn = '0;
   logic        ebusCS, ebusDemand, ebusDriving, busy, done, timeout;
   logic [2:0]  ebusFunc;
   logic [7:0]  ebusDev;
   logic [35:0] ebusDataOut, rdata;

   int vectors = 0;
   int miscompares = 0;

   ebus_xfer #(.SETUP_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .isRead(isRead),
      .func(func), .dev(dev), .wdata(wdata), .ebusXfer(ebusXfer),
      .ebusDataIn(ebusDataIn), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
      .ebusDev(ebusDev), .ebusDemand(ebusDemand), .ebusDriving(ebusDriving),
      .ebusDataOut(ebusDataOut), .rdata(rdata), .busy(busy), .done(done),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0o expected %0o at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: a transfer accepted at edge s owns the bus until
   // its completion edge; demand spans from edge s+S until the acknowledge edge
   // or the timeout edge s+S+T; release ends on xfer low or after T more edges.
   int          cyc = 0;
   bit          act = 0;
   int          s_edge = 0;
   int          rel_edge = -1;
   logic        m_rd = 1'b0;
   logic [2:0]  m_f = '0;
   logic [6:0]  m_d = '0;
   logic [35:0] m_w = '0;
   logic        ex_cs = 0, ex_dem = 0, ex_drv = 0, ex_busy = 0, ex_done = 0, ex_to = 0;
   logic [2:0]  ex_f = '0;
   logic [7:0]  ex_d = '0;
   logic [35:0] ex_do = '0, ex_rdata = '0;

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            act = 0; ex_cs = 0; ex_dem = 0; ex_drv = 0; ex_busy = 0;
            ex_done = 0; ex_to = 0; ex_f = '0; ex_d = '0; ex_do = '0; ex_rdata = '0;
         end else begin
            cyc++;
            ex_done = 0;
            ex_to = 0;
            if (!act) begin
               if (start) begin
                  act = 1; s_edge = cyc; rel_edge = -1;
                  m_rd = isRead; m_f = func; m_d = dev; m_w = wdata;
               end
            end else if (rel_edge < 0) begin
               if (cyc > s_edge + S) begin
                  if (ebusXfer) begin
                     rel_edge = cyc;
                     if (m_rd) ex_rdata = ebusDataIn;
                  end else if (cyc == s_edge + S + T) begin
                     act = 0; ex_done = 1; ex_to = 1;
                  end
               end
            end else begin
               if (!ebusXfer) begin
                  act = 0; ex_done = 1;
               end else if (cyc == rel_edge + T) begin
                  act = 0; ex_done = 1; ex_to = 1;
               end
            end
            ex_cs   = act;
            ex_busy = act;
            ex_dem  = act && rel_edge < 0 && cyc >= s_edge + S;
            ex_drv  = act && !m_rd;
            ex_do   = ex_drv ? m_w : 36'd0;
            ex_f    = act ? m_f : 3'd0;
            ex_d    = act ? {1'b0, m_d} : 8'd0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cs", ebusCS, ex_cs);
         chk("busy", busy, ex_busy);
         chk("demand", ebusDemand, ex_dem);
         chk("driving", ebusDriving, ex_drv);
         chk("dataout", ebusDataOut, ex_do);
         chk("func", ebusFunc, ex_f);
         chk("dev", ebusDev, ex_d);
         chk("rdata", rdata, ex_rdata);
         chk("done", done, ex_done);
         chk("timeout", timeout, ex_to);
      end
   end

   // Device responder: raises xfer dev_delay cycles after seeing demand and
   // drops it dev_hold cycles later (negative delay = never responds).
   int dev_delay = -1, dev_hold = 1, dcnt = 0, hcnt = 0;
   bit raised = 0;

   task automatic dev_clear(input int dly, input int hold);
      ebusXfer = 0; raised = 0; dcnt = 0; hcnt = 0;
      dev_delay = dly; dev_hold = hold;
   endtask

   task automatic tick();
      @(negedge clk);
      if (!raised) begin
         if (ebusDemand) begin
            if (dcnt == dev_delay) begin
               ebusXfer = 1; raised = 1; hcnt = 0;
            end
            dcnt++;
         end
      end else if (ebusXfer) begin
         hcnt++;
         if (hcnt == dev_hold) ebusXfer = 0;
      end
   endtask

   task automatic run(input logic rd, input logic [2:0] f, input logic [6:0] d,
                      input logic [35:0] w, input logic [35:0] din,
                      input int dly, input int hold,
                      output int n, output int dem, output logic drv_seen,
                      output logic [35:0] do_first, output logic [35:0] rd_before,
                      output logic to_at_done);
      bit fin;
      dev_clear(dly, hold);
      ebusDataIn = din; isRead = rd; func = f; dev = d; wdata = w; start = 1;
      n = 0; dem = 0; drv_seen = 0; to_at_done = 0; fin = 0;
      do_first = '0; rd_before = '0;
      while (!fin && n < 200) begin
         tick();
         if (n == 0) start = 0;
         n++;
         if (n == 1) do_first = ebusDataOut;
         if (ebusDriving) drv_seen = 1;
         if (ebusDemand) dem++;
         if (done) begin
            to_at_done = timeout;
            fin = 1;
         end else begin
            rd_before = rdata;
         end
      end
      if (!fin) begin
         miscompares++;
         $display("FAIL run_bound: no done within %0d cycles", n);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, dem, n2;
      logic drv, to;
      logic [35:0] dof, rdb;
      bit fin;

      #1 reset_n = 0;
      repeat (3) tick();
      chk("reset_busy", busy, 1'b0);
      chk("reset_cs", ebusCS, 1'b0);
      chk("reset_rdata", rdata, 36'd0);
      chk("reset_done", done, 1'b0);
      reset_n = 1;
      tick();

      // Write
      run(1'b0, 3'b101, 7'o040, 36'o123456701234, 36'd0, 2, 1, n, dem, drv, dof, rdb, to);
      chk("wr_latency", n, 7);
      chk("wr_demand_cycles", dem, 3);
      chk("wr_timeout", to, 1'b0);
      chk("wr_dataout_e1", dof, 36'o123456701234);
      chk("wr_driving", drv, 1'b1);
      chk("wr_rdata", rdata, 36'd0);

      // Read
      run(1'b1, 3'b011, 7'o100, 36'o111111111111, 36'o777000000777, 0, 1, n, dem, drv, dof, rdb, to);
      chk("rd_latency", n, 5);
      chk("rd_demand_cycles", dem, 1);
      chk("rd_before_done", rdb, 36'o777000000777);
      chk("rd_driving", drv, 1'b0);
      chk("rd_timeout", to, 1'b0);

      // No response
      run(1'b1, 3'b001, 7'o002, 36'd0, 36'o123, -1, 1, n, dem, drv, dof, rdb, to);
      chk("nr_latency", n, 67);
      chk("nr_timeout", to, 1'b1);
      chk("nr_rdata", rdata, 36'o777000000777);
      tick();
      chk("nr_cs_after", ebusCS, 1'b0);
      chk("nr_demand_after", ebusDemand, 1'b0);

      // Stuck xfer
      run(1'b1, 3'b001, 7'o003, 36'd0, 36'o000000000001, 0, 1000000, n, dem, drv, dof, rdb, to);
      chk("st_latency", n, 68);
      chk("st_timeout", to, 1'b1);
      chk("st_rdata", rdata, 36'o000000000001);
      dev_clear(-1, 1);
      tick();

      // start during DEMAND is ignored; start in the done cycle is accepted
      dev_clear(2, 1);
      isRead = 0; func = 3'b101; dev = 7'o040; wdata = 36'o707070707070; start = 1;
      n = 0; fin = 0;
      while (!fin && n < 200) begin
         tick();
         n++;
         if (n == 1) start = 0;
         if (n == 3) begin start = 1; func = 3'b111; dev = 7'o077; end
         if (n == 4) start = 0;
         if (n == 5) chk("ig_func_held", ebusFunc, 3'b101);
         if (done) fin = 1;
      end
      chk("ig_latency", n, 7);
      dev_clear(0, 1);
      start = 1; isRead = 1; func = 3'b010; dev = 7'o017; ebusDataIn = 36'o555;
      tick();
      start = 0;
      chk("bb_func", ebusFunc, 3'b010);
      chk("bb_dev", ebusDev, 8'o017);
      chk("bb_cs", ebusCS, 1'b1);
      n2 = 1; fin = 0;
      while (!fin && n2 < 200) begin
         tick();
         n2++;
         if (done) fin = 1;
      end
      chk("bb_latency", n2, 5);
      chk("bb_rdata", rdata, 36'o555);

      // Reset mid-DEMAND
      dev_clear(-1, 1);
      isRead = 1; func = 3'b110; dev = 7'o012; start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      chk("mr_in_demand", ebusDemand, 1'b1);
      #2 reset_n = 0;
      #1;
      chk("mr_cs", ebusCS, 1'b0);
      chk("mr_demand", ebusDemand, 1'b0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_func", ebusFunc, 3'd0);
      chk("mr_dev", ebusDev, 8'd0);
      chk("mr_rdata", rdata, 36'd0);
      chk("mr_done", done, 1'b0);
      repeat (2) tick();
      chk("mr_no_done", done, 1'b0);
      reset_n = 1;
      tick();
      run(1'b0, 3'b100, 7'o001, 36'o000111222333, 36'd0, 0, 1, n, dem, drv, dof, rdb, to);
      chk("mr_after_latency", n, 5);
      chk("mr_after_timeout", to, 1'b0);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
